// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: drives one active-low column at a time, samples synchronised
// active-low rows, debounces over whole scan frames and reports one raw key index per press.
module keypad_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 62501,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int REPEAT_SCANS   = 0,
  parameter int KW             = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            multi_key
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RW    = (REPEAT_SCANS > 0) ? $clog2(REPEAT_SCANS + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_SCANS - 1);
  localparam logic [RW-1:0]    REP_LAST = RW'(REPEAT_SCANS - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  // Row synchroniser; reset to 1s so idle (released) rows are seen as not pressed.
  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_sync;

  // NOTE: every clocked block uses non-blocking (<=) assignments so all registers
  // sample pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Column divider and scan pointer
  logic [DIV_W-1:0] div;
  logic [COL_W-1:0] col;
  logic             tc;
  logic             frame_end;

  assign tc        = (div == DIV_LAST);
  assign frame_end = tc && (col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      col <= '0;
    end else if (tc) begin
      div <= '0;
      col <= (col == COL_LAST) ? '0 : col + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign col_out = ~(COLS'(1) << col);

  // Rows pressed in the current column: saturating count and lowest row index.
  logic [1:0]       col_hits;
  logic [ROW_W-1:0] col_low_row;

  // NOTE: each always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    col_hits    = 2'd0;
    col_low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_sync[i]) begin
        col_low_row = ROW_W'(i);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  logic [KW-1:0] col_idx;
  assign col_idx = KW'(col) * KW'(ROWS) + KW'(col_low_row);

  // Frame accumulators merged with the column being sampled at this tc.
  logic [1:0]    acc_hits;
  logic [KW-1:0] acc_low;
  logic [1:0]    frame_hits;
  logic [KW-1:0] frame_low;

  always_comb begin
    frame_hits = acc_hits;
    frame_low  = acc_low;
    if (col_hits != 2'd0) begin
      // Earlier columns always hold lower indices, so only an empty frame takes col_idx.
      if (acc_hits == 2'd0) frame_low = col_idx;
      frame_hits = (acc_hits == 2'd0 && col_hits == 2'd1) ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits <= 2'd0;
      acc_low  <= '0;
    end else if (frame_end) begin
      acc_hits <= 2'd0;
      acc_low  <= '0;
    end else if (tc) begin
      acc_hits <= frame_hits;
      acc_low  <= frame_low;
    end
  end

  logic frame_single;
  logic frame_match;

  assign frame_single = (frame_hits == 2'd1);

  // Debounce / hold / repeat FSM; only frame evaluations move it.
  logic [1:0]    state;
  logic [KW-1:0] cand;
  logic [DW-1:0] cnt;
  logic [DW-1:0] rel;
  logic [RW-1:0] rep;

  assign frame_match = frame_single && (frame_low == cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      rel       <= '0;
      rep       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        multi_key <= (frame_hits == 2'd2);
        case (state)
          ST_IDLE: begin
            if (frame_single) begin
              cand <= frame_low;
              cnt  <= DW'(1);
              rel  <= '0;
              rep  <= '0;
              if (DEBOUNCE_SCANS == 1) begin
                state     <= ST_HELD;
                key_code  <= frame_low;
                key_valid <= 1'b1;
              end else begin
                state <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (frame_match) begin
              if (cnt == DEB_LAST) begin
                state     <= ST_HELD;
                key_code  <= cand;
                key_valid <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
          ST_HELD: begin
            if (frame_match) begin
              rel <= '0;
              if (REPEAT_SCANS > 0) begin
                if (rep == REP_LAST) begin
                  key_code  <= cand;
                  key_valid <= 1'b1;
                  rep       <= '0;
                end else begin
                  rep <= rep + 1'b1;
                end
              end
            end else begin
              // Any other result counts towards release; a new key must re-debounce from IDLE.
              rep <= '0;
              if (rel == DEB_LAST) begin
                state <= ST_IDLE;
                cnt   <= '0;
                rel   <= '0;
              end else begin
                rel <= rel + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign key_held = (state == ST_HELD);

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: 4x4 without and with repeat, plus a 2x3 variant,
// each driven by a behavioural keypad that pulls a row low while its key's column is driven.
module tb_keypad_matrix_scanner;

  logic clk;
  logic rst_n;

  logic [15:0] keys_a, keys_r;
  logic [5:0]  keys_v;

  logic [3:0] row_a, row_r, col_a, col_r, code_a, code_r;
  logic       kv_a, kh_a, mk_a, kv_r, kh_r, mk_r;
  logic [1:0] row_v;
  logic [2:0] col_v, code_v;
  logic       kv_v, kh_v, mk_v;

  int total = 0;
  int bad   = 0;
  int pulses_a = 0, pulses_r = 0, pulses_v = 0;
  int base;

  keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .row_in(row_a), .col_out(col_a), .key_code(code_a),
    .key_valid(kv_a), .key_held(kh_a), .multi_key(mk_a));

  keypad_matrix_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) dut_r (
    .clk(clk), .rst_n(rst_n), .row_in(row_r), .col_out(col_r), .key_code(code_r),
    .key_valid(kv_r), .key_held(kh_r), .multi_key(mk_r));

  keypad_matrix_scanner #(.ROWS(2), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(0)) dut_v (
    .clk(clk), .rst_n(rst_n), .row_in(row_v), .col_out(col_v), .key_code(code_v),
    .key_valid(kv_v), .key_held(kh_v), .multi_key(mk_v));

  function automatic logic [3:0] pad44(input logic [3:0] cols, input logic [15:0] keys);
    pad44 = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!cols[c] && keys[c*4+r]) pad44[r] = 1'b0;
  endfunction

  function automatic logic [1:0] pad23(input logic [2:0] cols, input logic [5:0] keys);
    pad23 = '1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 2; r++)
        if (!cols[c] && keys[c*2+r]) pad23[r] = 1'b0;
  endfunction

  assign row_a = pad44(col_a, keys_a);
  assign row_r = pad44(col_r, keys_r);
  assign row_v = pad23(col_v, keys_v);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters see the value registered at the previous edge.
  always @(posedge clk) begin
    if (kv_a) pulses_a++;
    if (kv_r) pulses_r++;
    if (kv_v) pulses_v++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance exactly n active edges, landing on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    keys_a = '0;
    keys_r = '0;
    keys_v = '0;
    tick(3);
    check("rst_col_a",   col_a,  4'b1110);
    check("rst_col_v",   col_v,  3'b110);
    check("rst_valid",   kv_a,   1'b0);
    check("rst_held",    kh_a,   1'b0);
    check("rst_multi",   mk_a,   1'b0);
    check("rst_code",    code_a, 4'd0);

    // Key 9 (col 2, row 1) accepted, then reset asserted mid-frame.
    keys_a = 16'h0001 << 9;
    rst_n  = 1'b1;
    tick(40);
    check("pre_rst_held", kh_a,   1'b1);
    check("pre_rst_code", code_a, 4'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async_col",   col_a,  4'b1110);
    check("async_held",  kh_a,   1'b0);
    check("async_code",  code_a, 4'd0);
    check("async_valid", kv_a,   1'b0);
    check("async_multi", mk_a,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = pulses_a;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("col_step%0d", k), col_a, exp_col);
      tick(1);
    end
    tick(11);
    check("no_early_pulse", pulses_a - base, 0);
    check("no_early_valid", kv_a, 1'b0);
    tick(1);
    check("first_valid", kv_a,   1'b1);
    check("first_code",  code_a, 4'd9);
    check("first_held",  kh_a,   1'b1);

    // Hold key 9 for 4 frames, release, expect a single press and 2-frame release.
    keys_a = 16'h0001 << 9;
    do_reset();
    base = pulses_a;
    tick(32);
    check("hold_valid", kv_a,   1'b1);
    check("hold_code",  code_a, 4'd9);
    check("hold_held",  kh_a,   1'b1);
    tick(32);
    check("hold_f4_held", kh_a, 1'b1);
    keys_a = '0;
    tick(16);
    check("rel1_held", kh_a, 1'b1);
    tick(16);
    check("rel2_held",  kh_a,   1'b0);
    check("rel_code",   code_a, 4'd9);
    check("hold_count", pulses_a - base, 1);

    // Bounce: visible, gone, visible, gone.
    keys_a = 16'h0001 << 9;
    do_reset();
    base = pulses_a;
    tick(16);
    check("bnc_f1_held", kh_a, 1'b0);
    keys_a = '0;
    tick(16);
    keys_a = 16'h0001 << 9;
    tick(16);
    check("bnc_f3_held", kh_a, 1'b0);
    keys_a = '0;
    tick(32);
    check("bnc_held",  kh_a, 1'b0);
    check("bnc_count", pulses_a - base, 0);
    check("bnc_code",  code_a, 4'd0);

    // Keys 1 and 6 together for 3 frames.
    keys_a = (16'h0001 << 1) | (16'h0001 << 6);
    do_reset();
    base = pulses_a;
    tick(16);
    check("mk_f1", mk_a, 1'b1);
    tick(32);
    check("mk_f3",      mk_a, 1'b1);
    check("mk_f3_held", kh_a, 1'b0);
    keys_a = '0;
    tick(16);
    check("mk_clear", mk_a, 1'b0);
    check("mk_count", pulses_a - base, 0);

    // Auto-repeat every 3 frames on key 5.
    keys_r = 16'h0001 << 5;
    do_reset();
    base = pulses_r;
    for (int f = 1; f <= 10; f++) begin
      logic exp_v;
      tick(16);
      exp_v = (f == 2 || f == 5 || f == 8);
      check($sformatf("rep_f%0d_valid", f), kv_r, exp_v);
      if (exp_v) check($sformatf("rep_f%0d_code", f), code_r, 4'd5);
    end
    tick(1);
    check("rep_count", pulses_r - base, 3);
    keys_r = '0;

    // 2x3 variant: key at col 2, row 1 -> index 5.
    keys_v = 6'b000001 << 5;
    do_reset();
    base = pulses_v;
    for (int k = 0; k < 14; k++) begin
      logic [2:0] exp_col;
      exp_col = ~(3'b001 << ((k / 4) % 3));
      check($sformatf("v_col%0d", k), col_v, exp_col);
      tick(1);
    end
    tick(10);
    check("v_valid", kv_v,   1'b1);
    check("v_code",  code_v, 3'd5);
    check("v_held",  kh_v,   1'b1);
    tick(12);
    check("v_f3_held", kh_v, 1'b1);
    check("v_count",   pulses_v - base, 1);
    keys_v = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised matrix-keypad scanner for the top-level keypad input path. It drives one active-low column at a time and samples active-low rows through a synchroniser. It debounces over whole scan frames and reports one raw key index per press, with optional auto-repeat. It generalises the fixed 4x4 scanner to any ROWS x COLS matrix and adds multi-key rejection and configurable debounce and repeat. Mapping the raw index to digit, ENTER, BACKSPACE and similar codes stays in the consumer.

## Interface
- ROWS, 4, number of row inputs (>=1)
- COLS, 4, number of column outputs (>=2)
- SCAN_DIV, 62501, clock cycles each column is driven (>=4)
- DEBOUNCE_SCANS, 2, consecutive identical scan frames needed to accept a press or a release (>=1)
- REPEAT_SCANS, 0, scan frames between auto-repeat pulses while held; 0 disables repeat
- KW, derived, $clog2(ROWS*COLS), minimum 1
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- row_in  in  ROWS  raw row lines, active-low, asynchronous to clk
- col_out  out  COLS  column drive, one-cold active-low
- key_code  out  KW  raw index of the last accepted key = col*ROWS + row
- key_valid  out  1  one-cycle pulse on each accepted press or repeat
- key_held  out  1  level, accepted key still held
- multi_key  out  1  level, last evaluated frame had two or more keys down

## Operation
- row_in passes through a 2-flop synchroniser before any use.
- Divider div runs 0..SCAN_DIV-1. Terminal count (tc) is div==SCAN_DIV-1.
- Column index col advances at tc and wraps from COLS-1 to 0.
- col_out = ~(1<<col).
- Rows are sampled only at tc, so each column settles for SCAN_DIV-1 cycles.
- Row i is pressed when synchronised row_in[i]==0 at the tc of column j. Its index is j*ROWS+i.
- Per frame, track the pressed count (saturating at 2) and the lowest pressed index.
- The frame is evaluated at the tc of column COLS-1. The result is NONE, SINGLE(k) or MULTI. The per-frame accumulators then clear.
- multi_key is set when a MULTI frame is evaluated. It clears when a NONE or SINGLE frame is evaluated.
- FSM states are IDLE, DEBOUNCE, HELD. State changes only on frame evaluation:
  - IDLE, SINGLE(k): cand=k, cnt=1. If DEBOUNCE_SCANS==1, emit and go to HELD; otherwise go to DEBOUNCE. NONE or MULTI: stay in IDLE.
  - DEBOUNCE, SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, emit and go to HELD. Any other result: go to IDLE with cnt=0.
  - HELD, SINGLE(cand): rel=0 and rep+1. If REPEAT_SCANS>0 and rep reaches REPEAT_SCANS, emit and set rep=0.
  - HELD, any other result (NONE, MULTI, other key): rel+1 and rep=0. When rel reaches DEBOUNCE_SCANS, go to IDLE.
- Emit means key_code<=cand and key_valid pulses. key_code holds its value until the next emit.
- key_held=1 exactly while in HELD.
- A press in another key while in HELD is ignored until release completes. That key must then re-debounce from IDLE.
- Counters are wide enough for their parameter and never wrap.

## Timing
- Reset values: col=0, col_out={1..1,0}, div=0, state IDLE, key_code=0, key_valid=0, key_held=0, multi_key=0, synchroniser=all 1s.
- One frame lasts COLS*SCAN_DIV cycles.
- key_valid, key_held, key_code and multi_key all update on the clock edge at the frame-evaluation tc, i.e. they are registered.
- key_valid is high for exactly one cycle.
- Press latency is DEBOUNCE_SCANS frames after the first frame that sees the key, plus up to one partial frame and 2 synchroniser cycles.
- Reset asserted mid-scan forces all reset values asynchronously.
- After reset release, scanning restarts at column 0 with div=0, and a partial frame is never evaluated.
- The next frame evaluation falls at cycle COLS*SCAN_DIV-1 after reset release.

## Test plan
- Reset mid-frame, with the key at code 9 down and DEBOUNCE_SCANS=2. Sim parameters: SCAN_DIV=4, 4x4. -> Outputs return to reset values immediately and col_out=4'b1110. After release col_out steps 1110,1101,1011,0111,1110, each for 4 cycles. The first key_valid appears no earlier than the 2nd full frame.
- Hold row_in[1] low only while col_out[2] is low, for 4 frames, then release. -> Exactly one key_valid, with key_code=9. key_held is high from that pulse until 2 NONE frames after release.
- Bounce: key 9 visible for 1 frame, then NONE, then visible for 1 frame. -> No key_valid and key_held stays 0.
- Keys 1 and 6 down together for 3 frames. -> multi_key=1 after the first frame, no key_valid. multi_key=0 after the first NONE frame.
- REPEAT_SCANS=3, key 5 held for 10 frames. -> key_valid pulses at the evaluations of frames 2, 5 and 8, each with key_code=5.
- Variant ROWS=2, COLS=3 (KW=3): key at col 2, row 1 held for 3 frames. -> key_code=5, and col_out cycles 110,101,011 with wrap.
